// File: rtl/cordic_mult_hs_if.sv
// Handshake bundle for cordic_mult_hs: operand channel (in_valid/in_ready/a/b)
// and result channel (out_valid/out_ready/c/ovf).
interface cordic_mult_hs_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface

// File: rtl/cordic_mult_hs.sv
// Sequential linear-CORDIC multiplier c = a*b with valid/ready handshakes and saturation.
// Define CORDIC_MULT_HS_ROUND_EN to carry G guard LSBs on y/z and round half up at the end.
module cordic_mult_hs #(
    parameter int N    = 16,
    parameter int ITER = N - 1,
    parameter int G    = 3
) (
    input  logic            clk,
    input  logic            rst,
    cordic_mult_hs_if.slave bus
);
`ifdef CORDIC_MULT_HS_ROUND_EN
    localparam int GB = G;
`else
    // G only matters when guard bits are carried.
    localparam int GB = 0 * G;
`endif
    localparam int XW = N + 1;
    localparam int YW = N + GB;
    localparam int ZW = N + 2 + GB;
    localparam int FW = N + 2;
    localparam int IW = $clog2(ITER + 1);

    localparam logic signed [FW-1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [FW-1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic signed [XW-1:0]   x_r, x_s;
    logic signed [YW-1:0]   y_r, y_s;
    logic signed [ZW-1:0]   z_r, z_s;
    logic        [IW-1:0]   i_r, i_s;
    logic        [N-1:0]    c_r, c_s;
    logic                   ovf_r, ovf_s;
    logic                   out_valid_r, out_valid_s;
    logic                   in_ready_r;
    logic signed [XW-1:0]   step_s;

    // Drops the guard bits (with round half up) so z lands in b's format.
    function automatic logic signed [FW-1:0] finalize(input logic signed [ZW-1:0] z);
`ifdef CORDIC_MULT_HS_ROUND_EN
        logic signed [ZW-1:0] t;
        t = z + (ZW'(1) << (G - 1));
        return t[ZW-1:G];
`else
        return z;
`endif
    endfunction

    // Clamps to the N-bit signed range; MSB of the result is the overflow flag.
    function automatic logic [N:0] saturate(input logic signed [FW-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, 1'b0, {(N-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, 1'b1, {(N-1){1'b0}}};
        end else begin
            return {1'b0, v[N-1:0]};
        end
    endfunction

    // Next-state and datapath: load on accept, one CORDIC step per clock in RUN.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        z_s         = z_r;
        i_s         = i_r;
        c_s         = c_r;
        ovf_s       = ovf_r;
        out_valid_s = out_valid_r;
        step_s      = XW'(1) << (N - 1 - int'(i_r));
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    x_s     = XW'($signed(bus.a));
                    y_s     = YW'($signed(bus.b)) <<< GB;
                    z_s     = '0;
                    i_s     = '0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!x_r[XW-1]) begin
                    x_s = x_r - step_s;
                    z_s = z_r + ZW'(y_r);
                end else begin
                    x_s = x_r + step_s;
                    z_s = z_r - ZW'(y_r);
                end
                y_s = y_r >>> 1;
                i_s = i_r + IW'(1);
                // The last step's result is captured straight into the output registers.
                if (i_r == IW'(ITER - 1)) begin
                    {ovf_s, c_s} = saturate(finalize(z_s));
                    out_valid_s  = 1'b1;
                    state_s      = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; rst discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            i_r         <= '0;
            c_r         <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            z_r         <= z_s;
            i_r         <= i_s;
            c_r         <= c_s;
            ovf_r       <= ovf_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= (state_s == IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.c         = c_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_cordic_mult_hs.sv
// Bench for cordic_mult_hs: vector table, back-pressure / back-to-back / reset sequences
// and random operands, all checked through a scoreboard against a spec-level model.
`timescale 1ns/1ps
module tb_cordic_mult_hs;
    localparam int N    = 16;
    localparam int ITER = N - 1;
`ifdef CORDIC_MULT_HS_ROUND_EN
    localparam int GB  = 3;
    localparam int TOL = 3;
`else
    localparam int GB  = 0;
    localparam int TOL = ITER + 2;
`endif

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] want;
    } vec_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] want;
        int           tol;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    int           checks = 0;
    int           errors = 0;
    int           outputs = 0;
    int           issued = 0;
    int           cyc = 0;
    exp_t         sb[$];
    int           accept_cyc[$];
    logic [N-1:0] cur_want;
    int           cur_tol;
    exp_t         mon_e;
    exp_t         acc_e;
    logic [N:0]   mon_m;
    longint       mon_d;
    longint       mon_p;

    cordic_mult_hs_if #(.N(N)) bus ();

    cordic_mult_hs #(.N(N), .ITER(ITER), .G(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Straight integer transcription of the iteration, returns {ovf, c}.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        longint x, y, z, f;
        x = longint'($signed(a));
        y = longint'($signed(b)) * (longint'(1) <<< GB);
        z = 0;
        for (int i = 0; i < ITER; i++) begin
            if (x >= 0) begin
                x = x - (longint'(1) <<< (N - 1 - i));
                z = z + y;
            end else begin
                x = x + (longint'(1) <<< (N - 1 - i));
                z = z - y;
            end
            y = y >>> 1;
        end
        if (GB > 0) f = (z + (longint'(1) <<< (GB - 1))) >>> GB;
        else        f = z;
        if (f > 32767)       return {1'b1, 16'h7FFF};
        else if (f < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, f[N-1:0]};
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_le(input string name, input longint got, input longint lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s got=%0d limit=%0d", name, got, lim);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: operands seen with in_valid&in_ready are accepted at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            acc_e.a    = bus.a;
            acc_e.b    = bus.b;
            acc_e.want = cur_want;
            acc_e.tol  = cur_tol;
            sb.push_back(acc_e);
            accept_cyc.push_back(cyc);
        end
    end

    // Scoreboard pop: a result handshake completes at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            outputs++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got=%h want=none", bus.c);
            end else begin
                mon_e = sb.pop_front();
                mon_m = model(mon_e.a, mon_e.b);
                check("model_c", bus.c, mon_m[N-1:0]);
                check("model_ovf", bus.ovf, mon_m[N]);
                mon_d = longint'($signed(bus.c)) - longint'($signed(mon_e.want));
                if (mon_d < 0) mon_d = -mon_d;
                check_le("accuracy", mon_d, mon_e.tol);
                mon_p = longint'($signed(mon_e.a)) * longint'($signed(mon_e.b));
                if (mon_p < 0) mon_p = -mon_p;
                if (mon_p < longint'(32768 - 2 * TOL) * 32768) check("ovf_in_range", bus.ovf, 0);
            end
        end
    end

    // Drives one operation and waits for its result; out_ready must already be 1.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] want, input int tol);
        int n;
        cur_want     = want;
        cur_tol      = tol;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        issued++;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        check("latency", n, ITER + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vt[10];
        logic [N:0] m;
        int         n;
        logic [N-1:0] ra, rb, rw;
        longint     p;

        vt[0] = '{16'h4000, 16'h4000, 16'h2000};
        // (-1)*(-1): the iteration stops a residual step short of +1.0, so it lands in range.
        vt[1] = '{16'h8000, 16'h8000, 16'h7FFF};
        vt[2] = '{16'h8000, 16'h4000, 16'hC000};
        vt[3] = '{16'h0000, 16'h1234, 16'h0000};
        vt[4] = '{16'h4000, 16'h8000, 16'hC000};
        vt[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFE};
        vt[6] = '{16'h2000, 16'h1234, 16'h048D};
        vt[7] = '{16'hC000, 16'h1000, 16'hF800};
        vt[8] = '{16'h6000, 16'hA000, 16'hB800};
        vt[9] = '{16'h0001, 16'h7FFF, 16'h0001};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        cur_want      = '0;
        cur_tol       = 0;
        #2;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_c", bus.c, 0);
        check("reset_ovf", bus.ovf, 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].want, TOL);
            step();
            check("ready_after_handshake", bus.in_ready, 1);
            check("valid_after_handshake", bus.out_valid, 0);
        end

        // Back-to-back with in_valid held high: accepts must be ITER+2 cycles apart.
        accept_cyc.delete();
        cur_want     = 16'h2000;
        cur_tol      = TOL;
        bus.a        = 16'h4000;
        bus.b        = 16'h4000;
        bus.in_valid = 1'b1;
        issued++;
        step();
        cur_want = 16'hC000;
        bus.a    = 16'h8000;
        bus.b    = 16'h4000;
        issued++;
        n = 0;
        while (accept_cyc.size() < 2 && n < 100) begin
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", accept_cyc.size(), 2);
        if (accept_cyc.size() == 2) check("b2b_interval", accept_cyc[1] - accept_cyc[0], ITER + 2);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        check("b2b_second_result", bus.out_valid, 1);
        step();
        check("b2b_drained", sb.size(), 0);

        // Back-pressure: result and flags hold, extra operands are ignored.
        bus.out_ready = 1'b0;
        m             = model(16'h6000, 16'hA000);
        cur_want      = 16'hB800;
        cur_tol       = TOL;
        bus.a         = 16'h6000;
        bus.b         = 16'hA000;
        bus.in_valid  = 1'b1;
        issued++;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        check("bp_latency", n, ITER + 1);
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("bp_hold", {bus.out_valid, bus.in_ready, bus.ovf, bus.c}, {1'b1, 1'b0, m[N], m[N-1:0]});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        check("bp_no_queued_op", sb.size(), 0);

        // Reset during iteration 7 discards the operation immediately.
        cur_want     = 16'h2000;
        bus.a        = 16'h4000;
        bus.b        = 16'h4000;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_c", bus.c, 0);
        check("rst_in_ready", bus.in_ready, 1);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.out_valid) n++;
        end
        check("rst_no_late_output", n, 0);
        run_op(16'hC000, 16'h1000, 16'hF800, TOL);
        step();

        // Random operands, with full-scale extremes mixed in.
        for (int r = 0; r < 1500; r++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (r % 8 == 1) ra = 16'h8000;
            if (r % 8 == 3) rb = 16'h8000;
            if (r % 8 == 5) rb = 16'h7FFF;
            p  = (longint'($signed(ra)) * longint'($signed(rb)) + 16384) >>> 15;
            if (p > 32767) p = 32767;
            rw = p[N-1:0];
            run_op(ra, rb, rw, TOL + 1);
            step();
        end

        step();
        check("scoreboard_empty", sb.size(), 0);
        check("output_count", outputs, issued);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
